// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: format selects,
// buffer occupancy states and the legality helper.
package imm_pkg;

    // Immediate format selects carried on in_imm_src.
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // Occupancy of the two-entry output buffer.
    //   BUF_EMPTY: main invalid
    //   BUF_ONE  : main valid, skid invalid
    //   BUF_FULL : main and skid valid
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_FULL  = 2'b10
    } buf_state_t;

    // Selects 101..111 have no defined format.
    function automatic logic imm_is_legal(input logic [2:0] sel);
        return (sel <= IMM_J);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out channel pair of the immediate generator.
//
// Handshake: both channels use valid/ready. A transfer happens on a rising
// clock edge where valid && ready. A producer holding valid high keeps its
// payload stable until the transfer; valid never depends on ready. On the
// output side out_imm/out_illegal stay frozen while out_valid && !out_ready.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:7]     in_instr;
    logic [2:0]      in_imm_src;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    // Environment side: offers instructions and consumes immediates.
    modport master (
        output in_valid,
        input  in_ready,
        output in_instr,
        output in_imm_src,
        input  out_valid,
        output out_ready,
        input  out_imm,
        input  out_illegal
    );

    // Generator side.
    modport slave (
        input  in_valid,
        output in_ready,
        input  in_instr,
        input  in_imm_src,
        output out_valid,
        input  out_ready,
        output out_imm,
        output out_illegal
    );

endinterface

// File: rtl/imm_decode.sv
// Combinational immediate extractor for I/S/B/U/J formats, sign-extended
// to XLEN. Reserved selects produce a zero immediate and raise illegal.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  logic [2:0]      sel,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_decode: XLEN must be 32 or 64");
        end
    endgenerate

    // Every format's 32-bit form already carries instr[31] in bit 31
    // (U included), so widening to 64 is a plain sign extension of it.
    logic [31:0] imm32;

    // Assemble the 32-bit immediate for the selected format.
    always_comb begin
        imm32 = '0;
        case (sel)
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Widen to XLEN and flag reserved selects.
    always_comb begin
        illegal   = !imm_is_legal(sel);
        imm       = {XLEN{imm32[31]}};
        imm[31:0] = imm32;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a two-entry skid buffer. The decode
// happens on the input side, so both buffer entries hold finished
// immediates. in_ready is a flop (low only when the skid entry is in use),
// so downstream back-pressure never reaches upstream combinationally.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit FLUSH_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    imm_gen_pipe_if.slave bus,
    output buf_state_t  dbg_state
);

    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr   (bus.in_instr),
        .sel     (bus.in_imm_src),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    buf_state_t      state;
    logic [XLEN-1:0] main_imm;
    logic            main_illegal;
    logic [XLEN-1:0] skid_imm;
    logic            skid_illegal;
    logic            out_valid_q;
    logic            in_ready_q;

    logic flush_eff;
    logic in_fire;
    logic out_fire;

    // Flush is ignored entirely when the feature is compiled out.
    assign flush_eff = FLUSH_EN ? flush : 1'b0;
    assign in_fire   = bus.in_valid && in_ready_q;
    assign out_fire  = out_valid_q && bus.out_ready;

    // Buffer occupancy FSM; main is always the entry presented downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BUF_EMPTY;
            main_imm     <= '0;
            main_illegal <= 1'b0;
            skid_imm     <= '0;
            skid_illegal <= 1'b0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (flush_eff) begin
            // Drop both entries; the payload registers keep their values.
            state       <= BUF_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (in_fire) begin
                        main_imm     <= dec_imm;
                        main_illegal <= dec_illegal;
                        out_valid_q  <= 1'b1;
                        state        <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (in_fire && out_fire) begin
                        // Main drains and is refilled in the same cycle.
                        main_imm     <= dec_imm;
                        main_illegal <= dec_illegal;
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                        state       <= BUF_EMPTY;
                    end else if (in_fire) begin
                        // Main is stalled; park the new entry in skid.
                        skid_imm     <= dec_imm;
                        skid_illegal <= dec_illegal;
                        in_ready_q   <= 1'b0;
                        state        <= BUF_FULL;
                    end
                end
                BUF_FULL: begin
                    if (out_fire) begin
                        main_imm     <= skid_imm;
                        main_illegal <= skid_illegal;
                        in_ready_q   <= 1'b1;
                        state        <= BUF_ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= BUF_EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = main_imm;
    assign bus.out_illegal = main_illegal;
    assign dbg_state       = state;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit and a 64-bit instance, a
// vector table for the formats, and hand-written back-pressure, flush
// and mid-stream reset sequences checked against an expected queue.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64)) bus64 ();

    buf_state_t dbg32;
    buf_state_t dbg64;

    imm_gen_pipe #(.XLEN(32), .FLUSH_EN(1'b1)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus32),
        .dbg_state (dbg32)
    );

    imm_gen_pipe #(.XLEN(64), .FLUSH_EN(1'b1)) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus64),
        .dbg_state (dbg64)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  sel;
        logic [63:0] imm;
        logic        ill;
    } vec_t;

    vec_t v32[13];
    vec_t v64[4];

    // ---------------- scoreboard (32-bit instance) ----------------
    logic [32:0] exp_q[$];      // {illegal, imm}
    logic [32:0] sb_e;
    logic [31:0] cur_imm;
    logic        cur_ill;

    always @(posedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            if (bus32.out_valid && bus32.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected_out: got %h with nothing expected", bus32.out_imm);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_out", {31'b0, bus32.out_illegal, bus32.out_imm}, {31'b0, sb_e});
                end
            end
            if (bus32.in_valid && bus32.in_ready)
                exp_q.push_back({cur_ill, cur_imm});
        end
    end

    always @(posedge clk) begin
        if (rst_n && bus32.in_valid)
            assert (!$isunknown(bus32.in_imm_src)) else $error("X on bus32.in_imm_src");
        if (rst_n && bus64.in_valid)
            assert (!$isunknown(bus64.in_imm_src)) else $error("X on bus64.in_imm_src");
    end

    // ---------------- driver tasks ----------------
    task automatic drive32(input vec_t v);
        bus32.in_valid   = 1'b1;
        bus32.in_instr   = v.instr[31:7];
        bus32.in_imm_src = v.sel;
        cur_imm          = v.imm[31:0];
        cur_ill          = v.ill;
    endtask

    task automatic idle32();
        bus32.in_valid   = 1'b0;
        bus32.in_imm_src = 3'b000;
    endtask

    task automatic drive64(input vec_t v);
        bus64.in_valid   = 1'b1;
        bus64.in_instr   = v.instr[31:7];
        bus64.in_imm_src = v.sel;
    endtask

    task automatic idle64();
        bus64.in_valid   = 1'b0;
        bus64.in_imm_src = 3'b000;
    endtask

    // Offer one vector on an empty 32-bit pipe with out_ready=1 and check
    // it one cycle after acceptance.
    task automatic single32(input string name, input vec_t v);
        @(negedge clk);
        check({name, "_in_ready"}, 64'(bus32.in_ready), 64'd1);
        drive32(v);
        @(negedge clk);
        idle32();
        check({name, "_valid"}, 64'(bus32.out_valid), 64'd1);
        check({name, "_imm"}, 64'(bus32.out_imm), v.imm);
        check({name, "_ill"}, 64'(bus32.out_illegal), 64'(v.ill));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        v32[0]  = '{32'hFFF00093, 3'b000, 64'hFFFF_FFFF, 1'b0};
        v32[1]  = '{32'hFFDFF06F, 3'b100, 64'hFFFF_FFFC, 1'b0};
        v32[2]  = '{32'h00000463, 3'b010, 64'h0000_0008, 1'b0};
        v32[3]  = '{32'hFE000E23, 3'b001, 64'hFFFF_FFFC, 1'b0};
        v32[4]  = '{32'h12345037, 3'b011, 64'h1234_5000, 1'b0};
        v32[5]  = '{32'hFFFFFFFF, 3'b110, 64'h0000_0000, 1'b1};
        v32[6]  = '{32'hFFFFFFFF, 3'b101, 64'h0000_0000, 1'b1};
        v32[7]  = '{32'hFFFFFFFF, 3'b111, 64'h0000_0000, 1'b1};
        v32[8]  = '{32'h7FF00013, 3'b000, 64'h0000_07FF, 1'b0};
        v32[9]  = '{32'h02000080, 3'b001, 64'h0000_0021, 1'b0};
        v32[10] = '{32'h80000063, 3'b010, 64'hFFFF_F000, 1'b0};
        v32[11] = '{32'h0080006F, 3'b100, 64'h0000_0008, 1'b0};
        v32[12] = '{32'h800000B7, 3'b011, 64'h8000_0000, 1'b0};

        v64[0] = '{32'h800000B7, 3'b011, 64'hFFFF_FFFF_8000_0000, 1'b0};
        v64[1] = '{32'hFFF00093, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        v64[2] = '{32'h7FFFF037, 3'b011, 64'h0000_0000_7FFF_F000, 1'b0};
        v64[3] = '{32'hFFFFFFFF, 3'b110, 64'h0000_0000_0000_0000, 1'b1};

        bus32.in_instr  = '0;
        bus32.out_ready = 1'b1;
        bus64.in_instr  = '0;
        bus64.out_ready = 1'b1;
        cur_imm = '0;
        cur_ill = 1'b0;
        idle32();
        idle64();

        // Reset and post-release state.
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_out_valid", 64'(bus32.out_valid), 64'd0);
        check("rel_out_imm", 64'(bus32.out_imm), 64'd0);
        check("rel_out_ill", 64'(bus32.out_illegal), 64'd0);
        check("rel_in_ready", 64'(bus32.in_ready), 64'd1);
        check("rel_state", 64'(dbg32), 64'(BUF_EMPTY));
        check("rel64_out_imm", bus64.out_imm, 64'd0);
        check("rel64_in_ready", 64'(bus64.in_ready), 64'd1);

        // Format table, XLEN=32.
        for (int i = 0; i < 13; i++)
            single32($sformatf("v32_%0d", i), v32[i]);

        // Format table, XLEN=64.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive64(v64[i]);
            @(negedge clk);
            idle64();
            check($sformatf("v64_%0d_valid", i), 64'(bus64.out_valid), 64'd1);
            check($sformatf("v64_%0d_imm", i), bus64.out_imm, v64[i].imm);
            check($sformatf("v64_%0d_ill", i), 64'(bus64.out_illegal), 64'(v64[i].ill));
        end

        // Back-pressure: three offered, two accepted, output frozen.
        @(negedge clk);
        bus32.out_ready = 1'b0;
        drive32(v32[8]);
        @(negedge clk);
        check("bp_ready_one", 64'(bus32.in_ready), 64'd1);
        check("bp_imm_a", 64'(bus32.out_imm), v32[8].imm);
        drive32(v32[9]);
        @(negedge clk);
        check("bp_ready_full", 64'(bus32.in_ready), 64'd0);
        check("bp_state_full", 64'(dbg32), 64'(BUF_FULL));
        drive32(v32[10]);
        repeat (2) begin
            @(negedge clk);
            check("bp_ready_held", 64'(bus32.in_ready), 64'd0);
            check("bp_imm_stable", 64'(bus32.out_imm), v32[8].imm);
            check("bp_valid_held", 64'(bus32.out_valid), 64'd1);
        end
        check("bp_accepted", 64'(exp_q.size()), 64'd2);
        idle32();
        bus32.out_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check("bp_empty_valid", 64'(bus32.out_valid), 64'd0);

        // Flush while FULL: nothing buffered ever comes out.
        bus32.out_ready = 1'b0;
        drive32(v32[0]);
        @(negedge clk);
        drive32(v32[1]);
        @(negedge clk);
        check("fl_state_full", 64'(dbg32), 64'(BUF_FULL));
        flush = 1'b1;
        drive32(v32[2]);
        @(negedge clk);
        flush = 1'b0;
        idle32();
        check("fl_out_valid", 64'(bus32.out_valid), 64'd0);
        check("fl_in_ready", 64'(bus32.in_ready), 64'd1);
        check("fl_imm_held", 64'(bus32.out_imm), v32[0].imm);
        check("fl_state", 64'(dbg32), 64'(BUF_EMPTY));
        bus32.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("fl_quiet", 64'(bus32.out_valid), 64'd0);
        single32("fl_after", v32[3]);

        // Reset mid-stream clears output without a clock edge.
        @(negedge clk);
        bus32.out_ready = 1'b0;
        drive32(v32[4]);
        @(negedge clk);
        idle32();
        check("mr_valid_before", 64'(bus32.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_async_valid", 64'(bus32.out_valid), 64'd0);
        check("mr_async_imm", 64'(bus32.out_imm), 64'd0);
        check("mr_async_ill", 64'(bus32.out_illegal), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus32.out_ready = 1'b1;
        @(negedge clk);
        check("mr_rel_ready", 64'(bus32.in_ready), 64'd1);
        check("mr_rel_valid", 64'(bus32.out_valid), 64'd0);
        single32("mr_after", v32[11]);

        repeat (3) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
